// File: rtl/lampball_ctrl.sv
// ---------------------------------------------------------------------------
// lampball_ctrl
//
// Game controller for the Lampball handball game. The ball is a single lit
// lamp in the external Bidshift register. The controller serves it, steps it
// one lamp per ball tick, judges hits, misses and fouls from the two player
// buttons, and keeps both scores until one player reaches WIN_SCORE.
//
// The left player owns lamp bit 7 and the right player owns lamp bit 0.
//
// Bidshift mode select (SEL):
//   00 hold
//   01 shift toward bit0 (SIR enters bit7)
//   10 shift toward bit7 (SIL enters bit0)
//   11 parallel load of SRIN
//
// Ports:
//   CK      in   1        system clock, rising edge
//   CLEAR   in   1        asynchronous active-low reset
//   BTNL    in   1        left player button (asynchronous, active-high)
//   BTNR    in   1        right player button (asynchronous, active-high)
//   SROUT   in   8        lamp pattern read back from Bidshift
//   SEL     out  2        Bidshift mode select
//   SRIN    out  8        Bidshift parallel load data
//   SIL     out  1        Bidshift left serial-in, tied to 0
//   SIR     out  1        Bidshift right serial-in, tied to 0
//   SCOREL  out  SCORE_W  left player score
//   SCORER  out  SCORE_W  right player score
//   WINL    out  1        left player has won
//   WINR    out  1        right player has won
// ---------------------------------------------------------------------------
module lampball_ctrl #(
    parameter int TICK_DIV  = 4,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 9
) (
    input  logic               CK,
    input  logic               CLEAR,
    input  logic               BTNL,
    input  logic               BTNR,
    input  logic [7:0]         SROUT,
    output logic [1:0]         SEL,
    output logic [7:0]         SRIN,
    output logic               SIL,
    output logic               SIR,
    output logic [SCORE_W-1:0] SCOREL,
    output logic [SCORE_W-1:0] SCORER,
    output logic               WINL,
    output logic               WINR
);

    localparam int                 CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_TO_B0 = 2'b01;
    localparam logic [1:0] SEL_TO_B7 = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    localparam logic [7:0] LAMP_LEFT  = 8'h80;
    localparam logic [7:0] LAMP_RIGHT = 8'h01;
    localparam logic [7:0] LAMP_OFF   = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_L,
        SERVE_R,
        MOVE_R,
        MOVE_L,
        POINT,
        GAMEOVER
    } state_t;

    typedef enum logic [1:0] {
        SRV_ANY,
        SRV_L,
        SRV_R
    } server_t;

    state_t             state, state_n;
    server_t            server, server_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               pending;
    logic [2:0]         syncl, syncr;
    logic               pl, pr;
    logic               tick;
    logic               left_pt, right_pt;
    logic [1:0]         sel_n;
    logic [7:0]         srin_n;
    logic [SCORE_W-1:0] scorel_n, scorer_n;
    logic               winl_n, winr_n;

    // The serial inputs of the lamp register only ever feed in dark lamps.
    assign SIL = 1'b0;
    assign SIR = 1'b0;

    // Ball tick: last count of the step divider.
    assign tick = (cnt == TICK_LAST);

    // Button front end. Two flops bring each pin into the clock domain, the
    // third remembers the previous synchronized level so a rising edge can be
    // turned into a registered one-cycle press pulse. Holding a button down
    // therefore yields exactly one press.
    always_ff @(posedge CK or negedge CLEAR) begin
        if (!CLEAR) begin
            syncl <= '0;
            syncr <= '0;
            pl    <= 1'b0;
            pr    <= 1'b0;
        end else begin
            syncl <= {syncl[1:0], BTNL};
            syncr <= {syncr[1:0], BTNR};
            pl    <= syncl[1] & ~syncl[2];
            pr    <= syncr[1] & ~syncr[2];
        end
    end

    // Game decisions. The Bidshift outputs are computed here for the cycle
    // after the coming clock edge, so every output leaves the block from a
    // register. While "pending" is set the lamp register is still applying
    // the previous non-hold command, so SROUT is stale and is not judged;
    // presses arriving in that cycle are dropped.
    always_comb begin
        state_n  = state;
        server_n = server;
        cnt_n    = '0;
        sel_n    = SEL_HOLD;
        srin_n   = SRIN;
        scorel_n = SCOREL;
        scorer_n = SCORER;
        winl_n   = WINL;
        winr_n   = WINR;
        left_pt  = 1'b0;
        right_pt = 1'b0;

        case (state)
            IDLE: begin
                // The left check comes first so a simultaneous press with
                // no preferred server goes to the left player.
                if (pl && (server != SRV_R)) begin
                    state_n = SERVE_L;
                    sel_n   = SEL_LOAD;
                    srin_n  = LAMP_LEFT;
                end else if (pr && (server != SRV_L)) begin
                    state_n = SERVE_R;
                    sel_n   = SEL_LOAD;
                    srin_n  = LAMP_RIGHT;
                end
            end

            SERVE_L: begin
                state_n = MOVE_R;
            end

            SERVE_R: begin
                state_n = MOVE_L;
            end

            MOVE_R: begin
                cnt_n = tick ? '0 : cnt + CNT_ONE;
                if (!pending) begin
                    if (pr) begin
                        // A press on the right end lamp is a return and
                        // takes priority over a tick in the same cycle.
                        if (SROUT == LAMP_RIGHT) begin
                            state_n = MOVE_L;
                            cnt_n   = '0;
                        end else begin
                            left_pt = 1'b1;
                        end
                    end else if ((SROUT == LAMP_OFF) ||
                                 (tick && (SROUT == LAMP_RIGHT))) begin
                        left_pt = 1'b1;
                    end else if (tick) begin
                        sel_n = SEL_TO_B0;
                    end
                end
            end

            MOVE_L: begin
                cnt_n = tick ? '0 : cnt + CNT_ONE;
                if (!pending) begin
                    if (pl) begin
                        if (SROUT == LAMP_LEFT) begin
                            state_n = MOVE_R;
                            cnt_n   = '0;
                        end else begin
                            right_pt = 1'b1;
                        end
                    end else if ((SROUT == LAMP_OFF) ||
                                 (tick && (SROUT == LAMP_LEFT))) begin
                        right_pt = 1'b1;
                    end else if (tick) begin
                        sel_n = SEL_TO_B7;
                    end
                end
            end

            POINT: begin
                state_n = (WINL || WINR) ? GAMEOVER : IDLE;
            end

            GAMEOVER: begin
                state_n = GAMEOVER;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Awarding a point blanks the lamps, credits the scorer, hands them
        // the next serve and checks for the end of the game. The score and
        // win flag change together with the blanking load.
        if (left_pt) begin
            state_n  = POINT;
            sel_n    = SEL_LOAD;
            srin_n   = LAMP_OFF;
            server_n = SRV_L;
            scorel_n = SCOREL + SCORE_ONE;
            if (scorel_n == WIN_VAL) begin
                winl_n = 1'b1;
            end
        end else if (right_pt) begin
            state_n  = POINT;
            sel_n    = SEL_LOAD;
            srin_n   = LAMP_OFF;
            server_n = SRV_R;
            scorer_n = SCORER + SCORE_ONE;
            if (scorer_n == WIN_VAL) begin
                winr_n = 1'b1;
            end
        end
    end

    // State, divider, settle flag and all Bidshift/score outputs. The settle
    // flag records that a non-hold command is on SEL this cycle, which means
    // SROUT will not show its effect until the cycle after.
    always_ff @(posedge CK or negedge CLEAR) begin
        if (!CLEAR) begin
            state   <= IDLE;
            server  <= SRV_ANY;
            cnt     <= '0;
            pending <= 1'b0;
            SEL     <= SEL_HOLD;
            SRIN    <= LAMP_OFF;
            SCOREL  <= '0;
            SCORER  <= '0;
            WINL    <= 1'b0;
            WINR    <= 1'b0;
        end else begin
            state   <= state_n;
            server  <= server_n;
            cnt     <= cnt_n;
            pending <= (sel_n != SEL_HOLD);
            SEL     <= sel_n;
            SRIN    <= srin_n;
            SCOREL  <= scorel_n;
            SCORER  <= scorer_n;
            WINL    <= winl_n;
            WINR    <= winr_n;
        end
    end

endmodule

// File: doc/lampball_ctrl.md
Name: lampball_ctrl

Overview:
- Game controller for the Lampball handball game. Drives the Bidshift lamp register through SEL/SRIN/SIL/SIR and reads SROUT back.
- Serves the ball, steps it one lamp per ball tick, and judges hits, misses and fouls from the two player buttons.
- Keeps both scores and flags the winner.
- Bidshift contract, fixed: SEL 00 hold, 01 shift toward bit0 (SIR enters bit7), 10 shift toward bit7 (SIL enters bit0), 11 parallel load SRIN.
- Left player owns bit7; right player owns bit0.

Parameters:
- TICK_DIV, 4, clock cycles per ball step (>=2).
- SCORE_W, 4, score counter width.
- WIN_SCORE, 9, score that ends the game (< 2^SCORE_W).

Ports:
- CK  in  1  system clock, rising edge.
- CLEAR  in  1  asynchronous active-low reset.
- BTNL  in  1  left player button, asynchronous, active-high.
- BTNR  in  1  right player button, asynchronous, active-high.
- SROUT  in  8  lamp pattern fed back from Bidshift.
- SEL  out  2  Bidshift mode select.
- SRIN  out  8  Bidshift parallel load data.
- SIL  out  1  Bidshift left serial-in, always 0.
- SIR  out  1  Bidshift right serial-in, always 0.
- SCOREL  out  SCORE_W  left player score.
- SCORER  out  SCORE_W  right player score.
- WINL  out  1  left player has won.
- WINR  out  1  right player has won.

Behaviour:
- Reset (CLEAR=0, async): SEL=00, SRIN=0, SIL=SIR=0, scores 0, WINL=WINR=0, state IDLE, server=ANY, tick counter 0, synchronizers cleared.
- Buttons: 2-flop synchronizer, then rising-edge detect. A press is a one-cycle pulse (pl/pr) 3 cycles after the pin rises. A held button produces one pulse only.
- Tick: counter runs 0..TICK_DIV-1 in MOVE states only. tick=1 when counter=TICK_DIV-1. Counter resets to 0 on entering any MOVE state.
- SEL is 00 in every cycle not listed below. All outputs are registered.
- IDLE:
  - SEL=00.
  - pl accepted if server is ANY or L; go to SERVE_L.
  - pr accepted if server is ANY or R; go to SERVE_R.
  - pl and pr in the same cycle with server=ANY: left wins.
- SERVE_L: one cycle, SEL=11, SRIN=8'b1000_0000, then MOVE_R. SERVE_R mirrors this: SRIN=8'b0000_0001, then MOVE_L.
- MOVE_R (ball travelling to bit0); MOVE_L is the exact mirror:
  - Hit: pr while SROUT==8'h01. SEL=00 this cycle, then MOVE_L with the counter reset. Hit beats tick in the same cycle.
  - Foul: pr while SROUT!=8'h01. Left scores; go to POINT.
  - Miss: tick while SROUT==8'h01, or SROUT==8'h00 at any time. No shift; left scores; go to POINT.
  - Otherwise, on tick: SEL=01 for one cycle.
  - pl is ignored in MOVE_R.
- POINT:
  - One cycle, SEL=11, SRIN=0 (lamps off). Scorer's counter increments.
  - server is set to the scorer.
  - If the new score equals WIN_SCORE: set WINL or WINR and go to GAMEOVER. Otherwise go to IDLE.
- GAMEOVER: SEL=00, buttons ignored. Held until CLEAR.
- Latency:
  - Serve pin edge to SEL=11: 4 cycles (3 for the synchronizer, 1 for the output register).
  - SROUT reflects SEL one clock after SEL is asserted. The controller must not judge SROUT in the cycle after a SEL!=00 cycle (one-cycle settle, tracked by a pending flag).
- Scores never wrap; the game ends before overflow.
- Reset mid-rally: immediate return to reset values. The lamp register is cleared separately by its own CLEAR.

Test Plan:
- Reset then pulse BTNL (TICK_DIV=4) -> SEL=11 with SRIN=80 once. Then SEL=01 pulses every 4 cycles. SROUT walks 80,40,...,01.
- Ball at SROUT=01, pulse BTNR before the next tick -> no SEL=01 issued. Then SEL=10 pulses; SROUT walks 02,04,...,80.
- Ball at 01, no press -> at the tick: SEL=11 with SRIN=00, SCOREL=1, state IDLE. BTNR ignored; BTNL re-serves.
- Ball at 08 moving right, pulse BTNR -> foul: SCOREL increments, lamps cleared.
- BTNL and BTNR pressed in the same cycle from reset IDLE -> left serve (SRIN=80). During MOVE_R, a BTNL press causes no change.
- SCORER=8 (WIN_SCORE=9), left misses -> SCORER=9, WINR=1, all later buttons ignored. CLEAR low mid-flight -> all outputs back to 0 asynchronously.
